// File: rtl/eth_lookup_header_extract.sv
// Per-port header extractor: captures dst/src MAC and VLAN from the first four
// frame words and issues one registered lookup request per qualifying frame.
module eth_lookup_header_extract #(
   parameter logic [4:0] PORT_NUM = 5'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] port_vlan,
   input  logic        rx_frame_start,
   input  logic        rx_frame_data_valid,
   input  logic [31:0] rx_frame_data,
   input  logic [2:0]  rx_frame_bytes_valid,
   input  logic        rx_frame_commit,
   input  logic        rx_frame_drop,
   output logic        lookup_en,
   output logic [11:0] lookup_src_vlan,
   output logic [47:0] lookup_src_mac,
   output logic [4:0]  lookup_src_port,
   output logic [47:0] lookup_dst_mac,
   output logic [15:0] runt_count,
   output logic [15:0] badvlan_count
);

   typedef enum logic [2:0] {IDLE, W0, W1, W2, W3, WAIT_END} state_t;

   state_t      state, state_nxt;
   logic [47:0] dst_cap, src_cap;
   logic        frame_end, full_word, part_word, in_hdr, hdr_adv;
   logic        is_tag, vid_rsvd;
   logic [11:0] vid, vlan_sel;
   logic        cap_w0, cap_w1, cap_w2, issue, runt_evt, badvlan_evt;

   assign frame_end = rx_frame_commit | rx_frame_drop;
   assign full_word = rx_frame_data_valid && (rx_frame_bytes_valid == 3'd4);
   assign part_word = rx_frame_data_valid && (rx_frame_bytes_valid != 3'd4);
   assign in_hdr    = (state == W0) || (state == W1) || (state == W2) || (state == W3);
   // A header word only counts when nothing else is happening to the frame.
   assign hdr_adv   = !rx_frame_start && !frame_end && full_word;
   assign is_tag    = (rx_frame_data[31:16] == 16'h8100);
   assign vid       = rx_frame_data[11:0];
   assign vid_rsvd  = is_tag && (vid == 12'hFFF);
   assign vlan_sel  = (is_tag && (vid != 12'h000)) ? vid : port_vlan;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (rx_frame_start) begin
         state_nxt = W0;
      end else begin
         case (state)
            W0, W1, W2, W3: begin
               if (frame_end)      state_nxt = IDLE;
               else if (full_word) state_nxt = (state == W3) ? WAIT_END : state_t'(state + 3'd1);
               else if (part_word) state_nxt = WAIT_END;
            end
            WAIT_END: if (frame_end) state_nxt = IDLE;
            default:  state_nxt = state;
         endcase
      end
   end

   always_comb begin
      cap_w0      = (state == W0) && hdr_adv;
      cap_w1      = (state == W1) && hdr_adv;
      cap_w2      = (state == W2) && hdr_adv;
      issue       = (state == W3) && hdr_adv && !vid_rsvd;
      badvlan_evt = (state == W3) && hdr_adv && vid_rsvd;
      // Start alone silently restarts; start with commit/drop still ends the old frame.
      runt_evt    = in_hdr && (frame_end || (!rx_frame_start && part_word));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dst_cap         <= '0;
         src_cap         <= '0;
         lookup_en       <= 1'b0;
         lookup_src_vlan <= '0;
         lookup_src_mac  <= '0;
         lookup_src_port <= PORT_NUM;
         lookup_dst_mac  <= '0;
         runt_count      <= '0;
         badvlan_count   <= '0;
      end else begin
         if (cap_w0) dst_cap[47:16] <= rx_frame_data;
         if (cap_w1) begin
            dst_cap[15:0]  <= rx_frame_data[31:16];
            src_cap[47:32] <= rx_frame_data[15:0];
         end
         if (cap_w2) src_cap[31:0] <= rx_frame_data;
         lookup_en       <= issue;
         lookup_src_port <= PORT_NUM;
         if (issue) begin
            lookup_src_vlan <= vlan_sel;
            lookup_src_mac  <= src_cap;
            lookup_dst_mac  <= dst_cap;
         end
         if (runt_evt && runt_count != 16'hFFFF)       runt_count    <= runt_count + 16'd1;
         if (badvlan_evt && badvlan_count != 16'hFFFF) badvlan_count <= badvlan_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_eth_lookup_header_extract.sv
// Scoreboard bench: expected lookups are queued when word 3 is driven and
// matched (fields and cycle) against lookup_en pulses sampled on negedge.
module tb_eth_lookup_header_extract;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] port_vlan;
   logic        rx_frame_start, rx_frame_data_valid, rx_frame_commit, rx_frame_drop;
   logic [31:0] rx_frame_data;
   logic [2:0]  rx_frame_bytes_valid;
   logic        lookup_en;
   logic [11:0] lookup_src_vlan;
   logic [47:0] lookup_src_mac, lookup_dst_mac;
   logic [4:0]  lookup_src_port;
   logic [15:0] runt_count, badvlan_count;

   eth_lookup_header_extract #(.PORT_NUM(5'd12)) dut (
      .clk(clk), .rst_n(rst_n), .port_vlan(port_vlan),
      .rx_frame_start(rx_frame_start), .rx_frame_data_valid(rx_frame_data_valid),
      .rx_frame_data(rx_frame_data), .rx_frame_bytes_valid(rx_frame_bytes_valid),
      .rx_frame_commit(rx_frame_commit), .rx_frame_drop(rx_frame_drop),
      .lookup_en(lookup_en), .lookup_src_vlan(lookup_src_vlan),
      .lookup_src_mac(lookup_src_mac), .lookup_src_port(lookup_src_port),
      .lookup_dst_mac(lookup_dst_mac), .runt_count(runt_count),
      .badvlan_count(badvlan_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] vlan;
      logic [47:0] src;
      logic [47:0] dst;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0, n_fail = 0;
   int   ncyc = 0, lk_last = -100, lk_prev = -100;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic start_pulse();
      rx_frame_start = 1'b1; tick(); rx_frame_start = 1'b0;
   endtask

   task automatic commit_pulse();
      rx_frame_commit = 1'b1; tick(); rx_frame_commit = 1'b0;
   endtask

   task automatic word(input logic [31:0] d, input logic [2:0] b);
      rx_frame_data = d; rx_frame_bytes_valid = b; rx_frame_data_valid = 1'b1;
      tick();
      rx_frame_data_valid = 1'b0; rx_frame_bytes_valid = 3'd0;
   endtask

   task automatic send_frame(input logic [47:0] d, input logic [47:0] s, input logic [31:0] w3,
                             input bit exp_lk, input logic [11:0] vl);
      exp_t e;
      start_pulse();
      word(d[47:16], 3'd4);
      word({d[15:0], s[47:32]}, 3'd4);
      word(s[31:0], 3'd4);
      if (exp_lk) begin
         e.vlan = vl; e.src = s; e.dst = d; e.cyc = ncyc + 2;
         q.push_back(e);
      end
      word(w3, 3'd4);
   endtask

   // Monitor: every lookup_en must match the head of the queue in cycle and fields.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         ncyc++;
         if (lookup_en) begin
            lk_prev = lk_last; lk_last = ncyc;
            if (q.size() == 0) chk("lookup_spurious", 1, 0);
            else begin
               e = q.pop_front();
               chk("lookup_cycle", ncyc, e.cyc);
               chk("lookup_vlan", lookup_src_vlan, e.vlan);
               chk("lookup_src", lookup_src_mac, e.src);
               chk("lookup_dst", lookup_dst_mac, e.dst);
               chk("lookup_port", lookup_src_port, 5'd12);
            end
         end else if (q.size() > 0 && q[0].cyc < ncyc) begin
            e = q.pop_front();
            chk("lookup_missing", 0, 1);
         end
      end
   end

   localparam logic [47:0] DST = 48'h02deadbeef0a;
   localparam logic [47:0] SRC = 48'h02deadbeef0c;

   initial begin
      rst_n = 1'b0; port_vlan = 12'd2;
      rx_frame_start = 1'b0; rx_frame_data_valid = 1'b0; rx_frame_data = '0;
      rx_frame_bytes_valid = 3'd0; rx_frame_commit = 1'b0; rx_frame_drop = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      chk("rst_lookup_en", lookup_en, 0);
      chk("rst_port", lookup_src_port, 5'd12);
      chk("rst_dst", lookup_dst_mac, 0);
      chk("rst_src", lookup_src_mac, 0);
      chk("rst_vlan", lookup_src_vlan, 0);
      chk("rst_runt", runt_count, 0);
      chk("rst_badvlan", badvlan_count, 0);

      send_frame(DST, SRC, 32'h0800_4500, 1'b1, 12'd2);
      commit_pulse();
      send_frame(48'h0a0b0c0d0e0f, 48'h111213141516, 32'h8100_6005, 1'b1, 12'd5);
      commit_pulse();
      send_frame(48'h2122232425_26, 48'h313233343536, 32'h8100_4000, 1'b1, 12'd2);
      commit_pulse();
      send_frame(DST, SRC, 32'h8100_0FFF, 1'b0, 12'd0);
      commit_pulse();
      tick();
      chk("badvlan_cnt", badvlan_count, 1);

      start_pulse(); word(32'h1, 3'd4); word(32'h2, 3'd4); commit_pulse();
      chk("runt_commit", runt_count, 1);
      start_pulse(); word(32'h1, 3'd4); word(32'h2, 3'd4); word(32'h3, 3'd4); word(32'h4400_0000, 3'd2);
      chk("runt_partial", runt_count, 2);
      commit_pulse();

      // Words with no preceding start must be ignored.
      word(32'h0102_0304, 3'd4); word(32'h0506_0708, 3'd4);
      word(32'h090a_0b0c, 3'd4); word(32'h0800_0000, 3'd4);
      tick();

      send_frame(48'h111111111111, 48'h222222222222, 32'h8100_0007, 1'b1, 12'd7);
      send_frame(48'h333333333333, 48'h444444444444, 32'h0806_0001, 1'b1, 12'd2);
      repeat (3) tick();
      chk("b2b_spacing", lk_last - lk_prev, 5);
      chk("hold_dst", lookup_dst_mac, 48'h333333333333);
      chk("hold_vlan", lookup_src_vlan, 12'd2);

      start_pulse(); word(32'hdead_0001, 3'd4); word(32'hdead_0002, 3'd4);
      send_frame(48'h555555555555, 48'h666666666666, 32'h8100_0abc, 1'b1, 12'habc);
      commit_pulse();
      tick();
      chk("midstart_runt", runt_count, 2);

      start_pulse(); word(32'h7777_7777, 3'd4); word(32'h7777_8888, 3'd4);
      rst_n = 1'b0; word(32'h8888_8888, 3'd4);
      rst_n = 1'b1; word(32'h0800_0000, 3'd4);
      commit_pulse();
      tick();
      chk("rstmid_runt", runt_count, 0);
      chk("rstmid_badvlan", badvlan_count, 0);
      chk("rstmid_dst", lookup_dst_mac, 0);
      chk("rstmid_port", lookup_src_port, 5'd12);

      // Start+commit every cycle: each cycle after the first ends a W0 frame as a runt.
      rx_frame_start = 1'b1; rx_frame_commit = 1'b1;
      repeat (65535) tick();
      chk("sat_pre", runt_count, 16'hFFFE);
      repeat (10) tick();
      chk("sat_runt", runt_count, 16'hFFFF);
      rx_frame_start = 1'b0; rx_frame_commit = 1'b0;
      repeat (4) tick();

      chk("queue_empty", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
